// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/arith/shift ops, Booth multiply and
// restoring signed divide, each iterating one bit per cycle.
module seq_alu #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic                 clock,
    input  logic                 clear,
    input  logic                 start,
    input  logic [4:0]           control,
    input  logic                 inc_pc,
    input  logic [WIDTH-1:0]     y,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result,
    output logic                 div_zero
);

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHRA = 5'b01000;
    localparam logic [4:0] OP_SHL  = 5'b01001;
    localparam logic [4:0] OP_ROR  = 5'b01010;
    localparam logic [4:0] OP_ROL  = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t               state_q, state_d;
    logic [SHW-1:0]       count_q, count_d;
    logic [WIDTH:0]       acc_q, acc_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 qm1_q, qm1_d;
    logic [WIDTH-1:0]     m_q, m_d;
    logic                 q_neg_q, q_neg_d;
    logic                 r_neg_q, r_neg_d;
    logic [2*WIDTH-1:0]   result_q, result_d;
    logic                 div_zero_q, div_zero_d;

    logic [WIDTH-1:0]     single_res;
    logic [SHW-1:0]       ror_amt;
    logic [SHW-1:0]       rol_amt;
    logic                 shift_big;
    logic [WIDTH-1:0]     y_mag;
    logic [WIDTH-1:0]     b_mag;
    logic [WIDTH:0]       booth_sum;
    logic [WIDTH:0]       div_shift;
    logic [WIDTH:0]       div_diff;
    logic [WIDTH-1:0]     quo_n;
    logic [WIDTH-1:0]     rem_n;

    // Rotates use {y,y} so a zero amount naturally returns y; rol is ror by -amt.
    always_comb begin
        shift_big = |b[WIDTH-1:SHW];
        ror_amt   = b[SHW-1:0];
        rol_amt   = -b[SHW-1:0];
        y_mag     = y[WIDTH-1] ? -y : y;
        b_mag     = b[WIDTH-1] ? -b : b;
        single_res = '0;
        case (control)
            OP_ADD:  single_res = y + b;
            OP_SUB:  single_res = y - b;
            OP_AND:  single_res = y & b;
            OP_OR:   single_res = y | b;
            OP_NEG:  single_res = -b;
            OP_NOT:  single_res = ~b;
            OP_SHR:  single_res = shift_big ? '0 : (y >> ror_amt);
            OP_SHL:  single_res = shift_big ? '0 : (y << ror_amt);
            OP_SHRA: single_res = shift_big ? {WIDTH{y[WIDTH-1]}}
                                            : $unsigned($signed(y) >>> ror_amt);
            OP_ROR:  single_res = WIDTH'({y, y} >> ror_amt);
            OP_ROL:  single_res = WIDTH'({y, y} >> rol_amt);
            default: single_res = '0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        acc_d      = acc_q;
        lo_d       = lo_q;
        qm1_d      = qm1_q;
        m_d        = m_q;
        q_neg_d    = q_neg_q;
        r_neg_d    = r_neg_q;
        result_d   = result_q;
        div_zero_d = div_zero_q;
        booth_sum  = acc_q;
        div_shift  = {acc_q[WIDTH-1:0], lo_q[WIDTH-1]};
        div_diff   = div_shift - {1'b0, m_q};
        quo_n      = '0;
        rem_n      = '0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    count_d    = '0;
                    div_zero_d = 1'b0;
                    if (inc_pc) begin
                        result_d = {{WIDTH{1'b0}}, b + ONE};
                        state_d  = FIN;
                    end else if (control == OP_MUL) begin
                        acc_d   = '0;
                        lo_d    = y;
                        qm1_d   = 1'b0;
                        m_d     = b;
                        state_d = MUL;
                    end else if (control == OP_DIV) begin
                        if (b == '0) begin
                            result_d   = '0;
                            div_zero_d = 1'b1;
                            state_d    = FIN;
                        end else begin
                            acc_d   = '0;
                            lo_d    = y_mag;
                            m_d     = b_mag;
                            q_neg_d = y[WIDTH-1] ^ b[WIDTH-1];
                            r_neg_d = y[WIDTH-1];
                            state_d = DIV;
                        end
                    end else begin
                        result_d = {{WIDTH{1'b0}}, single_res};
                        state_d  = FIN;
                    end
                end
            end
            MUL: begin
                // acc carries a guard bit so subtracting a MIN multiplicand cannot overflow
                case ({lo_q[0], qm1_q})
                    2'b01:   booth_sum = acc_q + {m_q[WIDTH-1], m_q};
                    2'b10:   booth_sum = acc_q - {m_q[WIDTH-1], m_q};
                    default: booth_sum = acc_q;
                endcase
                acc_d   = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
                lo_d    = {booth_sum[0], lo_q[WIDTH-1:1]};
                qm1_d   = lo_q[0];
                count_d = count_q + 1'b1;
                if (&count_q) begin
                    result_d = {acc_d[WIDTH-1:0], lo_d};
                    state_d  = FIN;
                end
            end
            DIV: begin
                if (!div_diff[WIDTH]) begin
                    acc_d = div_diff;
                    lo_d  = {lo_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = div_shift;
                    lo_d  = {lo_q[WIDTH-2:0], 1'b0};
                end
                count_d = count_q + 1'b1;
                if (&count_q) begin
                    quo_n    = q_neg_q ? -lo_d : lo_d;
                    rem_n    = r_neg_q ? -acc_d[WIDTH-1:0] : acc_d[WIDTH-1:0];
                    result_d = {rem_n, quo_n};
                    state_d  = FIN;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q    <= IDLE;
            count_q    <= '0;
            acc_q      <= '0;
            lo_q       <= '0;
            qm1_q      <= 1'b0;
            m_q        <= '0;
            q_neg_q    <= 1'b0;
            r_neg_q    <= 1'b0;
            result_q   <= '0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            acc_q      <= acc_d;
            lo_q       <= lo_d;
            qm1_q      <= qm1_d;
            m_q        <= m_d;
            q_neg_q    <= q_neg_d;
            r_neg_q    <= r_neg_d;
            result_q   <= result_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign busy     = (state_q == MUL) || (state_q == DIV);
    assign done     = (state_q == FIN);
    assign result   = result_q;
    assign div_zero = div_zero_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu: an independent behavioural model feeds a
// scoreboard queue whose entries are checked when done is observed.
module tb_seq_alu;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHRA = 5'b01000;
    localparam logic [4:0] OP_SHL  = 5'b01001;
    localparam logic [4:0] OP_ROR  = 5'b01010;
    localparam logic [4:0] OP_ROL  = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;

    logic        clock;
    logic        clear;
    logic        start;
    logic [4:0]  control;
    logic        inc_pc;
    logic [31:0] y;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [63:0] result;
    logic        div_zero;

    typedef struct {
        string       tag;
        logic [63:0] res;
        logic        dz;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    seq_alu #(.WIDTH(32)) dut (
        .clock    (clock),
        .clear    (clear),
        .start    (start),
        .control  (control),
        .inc_pc   (inc_pc),
        .y        (y),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .div_zero (div_zero)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic logic [64:0] model(input logic [4:0] c, input logic inc,
                                          input logic [31:0] yv, input logic [31:0] bv);
        logic [63:0]        r;
        logic               dz;
        logic [31:0]        amt;
        logic signed [31:0] q;
        logic signed [31:0] rm;
        r  = '0;
        dz = 1'b0;
        if (inc) begin
            r[31:0] = bv + 32'd1;
        end else begin
            case (c)
                OP_ADD:  r[31:0] = yv + bv;
                OP_SUB:  r[31:0] = yv - bv;
                OP_AND:  r[31:0] = yv & bv;
                OP_OR:   r[31:0] = yv | bv;
                OP_NEG:  r[31:0] = 32'd0 - bv;
                OP_NOT:  r[31:0] = ~bv;
                OP_SHR:  r[31:0] = yv >> bv;
                OP_SHL:  r[31:0] = yv << bv;
                OP_SHRA: r[31:0] = $signed(yv) >>> bv;
                OP_ROR: begin
                    amt = bv % 32;
                    r[31:0] = (amt == 0) ? yv : ((yv >> amt) | (yv << (32 - amt)));
                end
                OP_ROL: begin
                    amt = bv % 32;
                    r[31:0] = (amt == 0) ? yv : ((yv << amt) | (yv >> (32 - amt)));
                end
                OP_MUL:  r = $signed({{32{yv[31]}}, yv}) * $signed({{32{bv[31]}}, bv});
                OP_DIV: begin
                    if (bv == 32'd0) begin
                        dz = 1'b1;
                    end else if (yv == 32'h8000_0000 && bv == 32'hFFFF_FFFF) begin
                        r = {32'h0, 32'h8000_0000};
                    end else begin
                        q  = $signed(yv) / $signed(bv);
                        rm = $signed(yv) % $signed(bv);
                        r  = {rm, q};
                    end
                end
                default: r = '0;
            endcase
        end
        return {dz, r};
    endfunction

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus(input string tag, input logic [4:0] c, input logic inc,
                                  input logic [31:0] yv, input logic [31:0] bv,
                                  input logic [63:0] er, input logic edz, input int elat);
        exp_t        e;
        logic [31:0] rnd;
        e.tag = tag;
        e.res = er;
        e.dz  = edz;
        e.lat = elat;
        sb.push_back(e);
        @(negedge clock);
        clear   = 1'b1;
        control = c;
        inc_pc  = inc;
        y       = yv;
        b       = bv;
        start   = 1'b1;
        @(posedge clock);
        #1;
        start   = 1'b0;
        rnd     = $urandom;
        control = rnd[4:0];
        inc_pc  = rnd[5];
        y       = $urandom;
        b       = $urandom;
    endtask

    task automatic check_output();
        exp_t e;
        int   cyc;
        int   busy_cnt;
        cyc      = 1;
        busy_cnt = 0;
        while (done !== 1'b1 && cyc <= 100) begin
            if (busy === 1'b1) busy_cnt++;
            @(posedge clock);
            #1;
            cyc++;
        end
        e = sb.pop_front();
        check_val({e.tag, " latency"}, 64'(cyc), 64'(e.lat));
        check_val({e.tag, " result"}, result, e.res);
        check_val({e.tag, " div_zero"}, {63'd0, div_zero}, {63'd0, e.dz});
        check_val({e.tag, " busy cycles"}, 64'(busy_cnt), 64'(e.lat - 1));
        @(posedge clock);
        #1;
        check_val({e.tag, " done pulse"}, {63'd0, done}, 64'd0);
        check_val({e.tag, " result hold"}, result, e.res);
    endtask

    task automatic run_op(input string tag, input logic [4:0] c, input logic inc,
                          input logic [31:0] yv, input logic [31:0] bv,
                          input logic [63:0] er, input logic edz);
        int lat;
        lat = (!inc && (c == OP_MUL || (c == OP_DIV && bv != 32'd0))) ? 33 : 1;
        apply_stimulus(tag, c, inc, yv, bv, er, edz, lat);
        check_output();
    endtask

    task automatic run_model(input string tag, input logic [4:0] c, input logic inc,
                             input logic [31:0] yv, input logic [31:0] bv);
        logic [64:0] m;
        m = model(c, inc, yv, bv);
        run_op(tag, c, inc, yv, bv, m[63:0], m[64]);
    endtask

    initial begin
        clear   = 1'b0;
        start   = 1'b0;
        control = '0;
        inc_pc  = 1'b0;
        y       = '0;
        b       = '0;
        repeat (2) @(negedge clock);
        check_val("reset busy", {63'd0, busy}, 64'd0);
        check_val("reset done", {63'd0, done}, 64'd0);
        check_val("reset result", result, 64'd0);
        check_val("reset div_zero", {63'd0, div_zero}, 64'd0);

        run_op("add wrap", OP_ADD, 1'b0, 32'hFFFF_FFFF, 32'd1, 64'h0, 1'b0);
        run_op("mul -3*7", OP_MUL, 1'b0, 32'hFFFF_FFFD, 32'd7, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0);
        run_op("div -7/2", OP_DIV, 1'b0, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0);
        run_op("div by 0", OP_DIV, 1'b0, 32'd5, 32'd0, 64'h0, 1'b1);
        run_op("div MIN/-1", OP_DIV, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 1'b0);
        run_op("ror 33", OP_ROR, 1'b0, 32'h1, 32'd33, 64'h8000_0000, 1'b0);
        run_op("shra 40", OP_SHRA, 1'b0, 32'h8000_0000, 32'd40, 64'hFFFF_FFFF, 1'b0);
        run_op("inc_pc", OP_MUL, 1'b1, 32'h1234_5678, 32'h10, 64'h11, 1'b0);

        run_model("and", OP_AND, 1'b0, 32'hF0F0_1234, 32'h0FF0_FF00);
        run_model("or", OP_OR, 1'b0, 32'hF000_0001, 32'h0000_1100);
        run_model("not", OP_NOT, 1'b0, 32'h1, 32'h00FF_00FF);
        run_model("sub", OP_SUB, 1'b0, 32'd3, 32'd10);
        run_model("neg", OP_NEG, 1'b0, 32'd9, 32'd1);
        run_model("shl 4", OP_SHL, 1'b0, 32'h8765_4321, 32'd4);
        run_model("shl 32", OP_SHL, 1'b0, 32'hFFFF_FFFF, 32'd32);
        run_model("shr 31", OP_SHR, 1'b0, 32'h8000_0000, 32'd31);
        run_model("shr big", OP_SHR, 1'b0, 32'hFFFF_FFFF, 32'h0001_0000);
        run_model("shra 4", OP_SHRA, 1'b0, 32'h8000_00F0, 32'd4);
        run_model("rol 0", OP_ROL, 1'b0, 32'hDEAD_BEEF, 32'd64);
        run_model("rol 4", OP_ROL, 1'b0, 32'hDEAD_BEEF, 32'd4);
        run_model("mul MIN*MIN", OP_MUL, 1'b0, 32'h8000_0000, 32'h8000_0000);
        run_model("mul mixed", OP_MUL, 1'b0, 32'd12345, 32'hFFFF_FD5A);
        run_model("div 100/-7", OP_DIV, 1'b0, 32'd100, 32'hFFFF_FFF9);
        run_model("div -100/7", OP_DIV, 1'b0, 32'hFFFF_FF9C, 32'd7);
        run_model("unknown op", 5'b11111, 1'b0, 32'h1234, 32'h5678);

        // Start held high: the cycle in FIN must not accept it, the following IDLE cycle must.
        @(negedge clock);
        control = OP_ADD;
        inc_pc  = 1'b0;
        y       = 32'd1;
        b       = 32'd1;
        start   = 1'b1;
        @(posedge clock);
        #1;
        check_val("b2b first done", {63'd0, done}, 64'd1);
        check_val("b2b first result", result, 64'd2);
        y = 32'd5;
        @(posedge clock);
        #1;
        check_val("b2b fin ignores start", {63'd0, done}, 64'd0);
        @(posedge clock);
        #1;
        check_val("b2b second done", {63'd0, done}, 64'd1);
        check_val("b2b second result", result, 64'd6);
        start = 1'b0;
        @(posedge clock);

        run_op("inc_pc pre-reset", OP_ADD, 1'b1, 32'd0, 32'h10, 64'h11, 1'b0);

        // Abort a multiply in its tenth cycle with an asynchronous clear.
        @(negedge clock);
        control = OP_MUL;
        inc_pc  = 1'b0;
        y       = 32'hFFFF_FFFD;
        b       = 32'd7;
        start   = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (8) @(posedge clock);
        @(posedge clock);
        #3;
        check_val("mid-mul busy", {63'd0, busy}, 64'd1);
        clear = 1'b0;
        #1;
        check_val("clear busy", {63'd0, busy}, 64'd0);
        check_val("clear done", {63'd0, done}, 64'd0);
        check_val("clear result", result, 64'd0);
        check_val("clear div_zero", {63'd0, div_zero}, 64'd0);

        run_op("add after clear", OP_ADD, 1'b0, 32'd2, 32'd3, 64'd5, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter WIDTH, default 32, operand width; power of two, 8 to 64.
REQ-002 Parameter SHW, default $clog2(WIDTH), shift-amount field width taken from b.
REQ-003 clock  input  1  single clock; all state updates on the rising edge.
REQ-004 clear  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  request strobe; sampled only in IDLE.
REQ-006 control  input  5  opcode: and 00101, or 00110, shr 00111, shra 01000, shl 01001, ror 01010, rol 01011, add 00011, sub 00100, mul 01111, div 10000, neg 10001, not 10010.
REQ-007 inc_pc  input  1  when high at start, overrides control; result = b + 1.
REQ-008 y  input  WIDTH  first operand (the Y temp register value).
REQ-009 b  input  WIDTH  second operand, or shift/rotate amount.
REQ-010 busy  output  1  high from the cycle after accepted start until done.
REQ-011 done  output  1  one-cycle pulse; result valid.
REQ-012 result  output  2*WIDTH  low half: 32-bit-style result / product low / quotient; high half: product high / remainder, zero for other ops.
REQ-013 div_zero  output  1  valid with done; high only for div with b = 0.

Function
REQ-014 FSM states IDLE, MUL, DIV, FIN; reset state IDLE.
REQ-015 IDLE + start: latch y, b, control, inc_pc; single-cycle ops go to FIN; mul goes to MUL; div with b != 0 goes to DIV; div with b = 0 goes to FIN.
REQ-016 start in MUL, DIV or FIN is ignored; operand changes after acceptance have no effect.
REQ-017 FIN: done = 1 for exactly one cycle, then IDLE; result updates on FIN entry and holds until the next FIN.
REQ-018 Latency, start edge to done high: single-cycle ops, inc_pc, div-by-zero and unknown opcodes = 1 cycle; mul and div = WIDTH + 1 cycles.
REQ-019 Back-to-back: start is accepted in the cycle done is high only if the FSM is already in IDLE; it is not accepted in FIN. Minimum issue interval is 2 cycles.
REQ-020 and/or/not: bitwise, not logical.
REQ-021 add/sub/neg: modulo 2^WIDTH; sub = y - b; neg = 0 - b; carry discarded.
REQ-022 shl/shr: amount = full b; b >= WIDTH gives 0.
REQ-023 shra: arithmetic; b >= WIDTH gives all sign bits.
REQ-024 ror/rol: amount = b mod WIDTH; amount 0 returns y unchanged.
REQ-025 mul: signed radix-2 Booth, one iteration per MUL cycle, 2*WIDTH signed product.
REQ-026 div: signed, one non-restoring or restoring step per DIV cycle.
REQ-027 div quotient truncates toward zero; remainder takes the dividend's sign.
REQ-028 div MIN / -1: quotient = MIN, remainder = 0, div_zero = 0.
REQ-029 div by zero: result = 0, div_zero = 1.
REQ-030 Unknown opcode: result = 0.
REQ-031 inc_pc: upper half = 0.

Reset
REQ-032 clear low, at any time including mid-MUL or mid-DIV, immediately forces state IDLE, busy 0, done 0, div_zero 0, result 0, and clears the iteration counter.
REQ-033 First start is accepted on the first rising edge with clear high.

Verification (WIDTH = 32)
REQ-034 add y = 0xFFFFFFFF, b = 1 -> done 1 cycle later; result 0x0000000000000000.
REQ-035 mul y = -3, b = 7 -> busy for 32 cycles; done at cycle 33; result 0xFFFFFFFFFFFFFFEB.
REQ-036 div y = -7, b = 2 -> done at cycle 33; low half 0xFFFFFFFD, high half 0xFFFFFFFF.
REQ-037 div by zero, and div 0x80000000 by -1:
- y = 5, b = 0 -> done at cycle 1, div_zero 1, result 0.
- y = 0x80000000, b = -1 -> low half 0x80000000, high half 0.
REQ-038 Shifts, rotates and inc_pc:
- ror y = 0x00000001, b = 33 -> 0x80000000.
- shra y = 0x80000000, b = 40 -> 0xFFFFFFFF.
- inc_pc b = 0x10 -> 0x11.
REQ-039 Reset mid-operation: clear low at cycle 10 of a mul -> all outputs 0 at once. Next start with add y = 2, b = 3 -> result 5.
